lcd_bus_writer: RTL and testbench

Byte-level driver for an HD44780-class character LCD, sitting between the LCD sequencing controller and the LCD pins. A transfer is requested with an active-low `lcd_enable` level plus a byte count, mode and register select. The block fetches each byte from the external data mux via `byte_idx`, generates the RS/DB/E write cycle with mode-dependent settle time, and returns a single-cycle `lcd_finish` pulse when the last byte is written.

---
 rtl/lcd_bus_writer.sv | 132 +++++++++++++
 tb/tb_lcd_bus_writer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_writer.sv
// rtl/lcd_bus_writer.sv - byte-level write cycle generator for an HD44780-class character LCD
//
// Ports:
//   clk_1ms    : clock, all logic on the rising edge
//   reset_n    : asynchronous active-low reset
//   lcd_enable : transfer request, a high-to-low transition starts a transfer
//   lcd_cnt    : number of bytes minus one, latched at start
//   mode       : 1 = init (INIT_WAIT settle), 0 = refresh (REF_WAIT settle), latched at start
//   reg_sel    : RS value for the whole transfer, latched at start
//   db_in      : byte returned by the external mux for byte_idx
//   byte_idx   : index of the byte currently requested from the mux
//   lcd_e      : LCD enable strobe
//   lcd_rs     : LCD register select
//   lcd_rw     : LCD read/write, tied to write
//   lcd_db     : LCD data bus
//   lcd_finish : one-cycle pulse when the last byte's settle time has elapsed
//   busy       : high from transfer start until the cycle after lcd_finish
module lcd_bus_writer #(
    parameter int INIT_WAIT = 5,
    parameter int REF_WAIT  = 1
) (
    input  logic       clk_1ms,
    input  logic       reset_n,
    input  logic       lcd_enable,
    input  logic [1:0] lcd_cnt,
    input  logic       mode,
    input  logic       reg_sel,
    input  logic [7:0] db_in,
    output logic [1:0] byte_idx,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db,
    output logic       lcd_finish,
    output logic       busy
);

    // Counter reload values: the WAIT state lasts W cycles including the one where it hits zero.
    localparam logic [3:0] INIT_LOAD = 4'(INIT_WAIT - 1);
    localparam logic [3:0] REF_LOAD  = 4'(REF_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state;
    logic       en_q;
    logic [1:0] cnt_q;
    logic       mode_q;
    logic       rs_q;
    logic [3:0] wait_cnt;

    assign lcd_rw = 1'b0;

    always_ff @(posedge clk_1ms or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            en_q       <= 1'b1;   // a request held low through reset starts on release
            cnt_q      <= 2'd0;
            mode_q     <= 1'b0;
            rs_q       <= 1'b0;
            wait_cnt   <= 4'd0;
            byte_idx   <= 2'd0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_db     <= 8'h00;
            lcd_finish <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // en_q tracks the request every cycle, so a falling edge seen while
            // busy is consumed and cannot start a transfer later.
            en_q       <= lcd_enable;
            lcd_finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!lcd_enable && en_q) begin
                        state    <= S_ADDR;
                        byte_idx <= 2'd0;
                        busy     <= 1'b1;
                        cnt_q    <= lcd_cnt;
                        mode_q   <= mode;
                        rs_q     <= reg_sel;
                    end
                end
                S_ADDR: begin
                    lcd_db <= db_in;
                    lcd_rs <= rs_q;
                    state  <= S_SETUP;
                end
                S_SETUP: begin
                    lcd_e <= 1'b1;
                    state <= S_PULSE;
                end
                S_PULSE: begin
                    lcd_e <= 1'b0;
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    wait_cnt <= mode_q ? INIT_LOAD : REF_LOAD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        if (byte_idx == cnt_q) begin
                            lcd_finish <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_ADDR;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb/tb_lcd_bus_writer.sv - directed self-checking bench for lcd_bus_writer
module tb_lcd_bus_writer;

    logic       clk_1ms;
    logic       reset_n;
    logic       lcd_enable;
    logic [1:0] lcd_cnt;
    logic       mode;
    logic       reg_sel;
    logic [7:0] db_in;
    logic [1:0] byte_idx;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db;
    logic       lcd_finish;
    logic       busy;

    logic [3:0][7:0] mux_data;
    int              cyc;
    int              tests_run;
    int              tests_failed;

    lcd_bus_writer #(.INIT_WAIT(5), .REF_WAIT(1)) dut (
        .clk_1ms    (clk_1ms),
        .reset_n    (reset_n),
        .lcd_enable (lcd_enable),
        .lcd_cnt    (lcd_cnt),
        .mode       (mode),
        .reg_sel    (reg_sel),
        .db_in      (db_in),
        .byte_idx   (byte_idx),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_db     (lcd_db),
        .lcd_finish (lcd_finish),
        .busy       (busy)
    );

    assign db_in = mux_data[byte_idx];

    initial clk_1ms = 1'b0;
    always #5 clk_1ms = ~clk_1ms;

    initial cyc = 0;
    always @(posedge clk_1ms) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transfer, edge k = first posedge after the request is applied.
    // pulse_off[j] and fin_off are hand-computed edge offsets from k.
    task automatic run_xfer(input string tag, input logic [1:0] cnt, input logic md, input logic rs,
                            input logic [3:0][7:0] data, input logic [3:0][7:0] pulse_off,
                            input int fin_off, input bit disturb, input bit from_reset);
        int k, off, npulse, nfin, fin_seen, n;
        logic [3:0][7:0] got_off, got_db;
        logic [3:0]      got_rs;
        logic [3:0][1:0] got_idx;
        logic busy_start, busy_fin, busy_after;
        npulse = 0; nfin = 0; fin_seen = -1; n = int'(cnt) + 1;
        got_off = '0; got_db = '0; got_rs = '0; got_idx = '0;
        busy_start = 1'b0; busy_fin = 1'b0; busy_after = 1'b1;
        @(negedge clk_1ms);
        mux_data = data; lcd_cnt = cnt; mode = md; reg_sel = rs;
        if (from_reset) reset_n = 1'b1;
        else lcd_enable = 1'b0;
        k = cyc + 1;
        for (int i = 0; i < fin_off + 7; i++) begin
            @(negedge clk_1ms);
            off = cyc - k;
            if (lcd_e) begin
                if (npulse < 4) begin
                    got_off[npulse] = 8'(off);
                    got_db[npulse]  = lcd_db;
                    got_rs[npulse]  = lcd_rs;
                    got_idx[npulse] = byte_idx;
                end
                npulse++;
            end
            if (lcd_finish) begin
                nfin++;
                fin_seen = off;
            end
            if (off == 0) busy_start = busy;
            if (off == fin_off) busy_fin = busy;
            if (off == fin_off + 1) busy_after = busy;
            if (!disturb) begin
                if (off == 1) lcd_enable = 1'b1;
            end else begin
                case (off)
                    3: lcd_enable = 1'b1;
                    5: begin
                        lcd_enable = 1'b0;
                        lcd_cnt = ~cnt; mode = ~md; reg_sel = ~rs;
                    end
                    10: lcd_enable = 1'b1;
                    default: ;
                endcase
            end
        end
        check({tag, "_npulse"}, npulse, n);
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s_e_at%0d", tag, j), got_off[j], pulse_off[j]);
            check($sformatf("%s_db%0d", tag, j), got_db[j], data[j]);
            check($sformatf("%s_rs%0d", tag, j), got_rs[j], rs);
            check($sformatf("%s_idx%0d", tag, j), got_idx[j], j);
        end
        check({tag, "_nfin"}, nfin, 1);
        check({tag, "_fin_at"}, fin_seen, fin_off);
        check({tag, "_busy_start"}, busy_start, 1);
        check({tag, "_busy_fin"}, busy_fin, 1);
        check({tag, "_busy_after"}, busy_after, 0);
        lcd_enable = 1'b1; lcd_cnt = cnt; mode = md; reg_sel = rs;
    endtask

    localparam logic [3:0][7:0] INIT_DATA  = {8'h01, 8'h06, 8'h0C, 8'h38};
    localparam logic [3:0][7:0] INIT_PULSE = {8'd29, 8'd20, 8'd11, 8'd2};
    localparam logic [3:0][7:0] ADDR_DATA  = {8'h00, 8'h00, 8'h00, 8'h80};
    localparam logic [3:0][7:0] ADDR_PULSE = {8'd0, 8'd0, 8'd0, 8'd2};
    localparam logic [3:0][7:0] OPEN_DATA  = {8'h4E, 8'h45, 8'h50, 8'h4F};
    localparam logic [3:0][7:0] OPEN_PULSE = {8'd17, 8'd12, 8'd7, 8'd2};

    initial begin
        tests_run = 0;
        tests_failed = 0;

        // Reset held with random inputs
        reset_n    = 1'b0;
        lcd_enable = 1'($urandom);
        lcd_cnt    = 2'($urandom);
        mode       = 1'($urandom);
        reg_sel    = 1'($urandom);
        mux_data   = 32'($urandom);
        repeat (3) @(negedge clk_1ms);
        check("rst_e", lcd_e, 0);
        check("rst_finish", lcd_finish, 0);
        check("rst_busy", busy, 0);
        check("rst_db", lcd_db, 8'h00);
        check("rst_idx", byte_idx, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);

        // Request held low through reset starts on release: address write timing
        lcd_enable = 1'b0;
        run_xfer("rstrel", 2'd0, 1'b0, 1'b0, ADDR_DATA, ADDR_PULSE, 5, 1'b0, 1'b1);

        run_xfer("init", 2'd3, 1'b1, 1'b0, INIT_DATA, INIT_PULSE, 36, 1'b0, 1'b0);
        run_xfer("addr", 2'd0, 1'b0, 1'b0, ADDR_DATA, ADDR_PULSE, 5, 1'b0, 1'b0);
        run_xfer("open", 2'd3, 1'b0, 1'b1, OPEN_DATA, OPEN_PULSE, 20, 1'b0, 1'b0);
        run_xfer("open_dist", 2'd3, 1'b0, 1'b1, OPEN_DATA, OPEN_PULSE, 20, 1'b1, 1'b0);
        run_xfer("init_dist", 2'd3, 1'b1, 1'b0, INIT_DATA, INIT_PULSE, 36, 1'b1, 1'b0);

        // Reset asserted mid-PULSE clears outputs without a clock edge
        @(negedge clk_1ms);
        mux_data = {8'h00, 8'h00, 8'h00, 8'h5A};
        lcd_cnt = 2'd0; mode = 1'b1; reg_sel = 1'b1; lcd_enable = 1'b0;
        for (int i = 0; i < 10 && !lcd_e; i++) @(negedge clk_1ms);
        check("midp_e_seen", lcd_e, 1);
        check("midp_db_before", lcd_db, 8'h5A);
        #1 reset_n = 1'b0;
        #1;
        check("midp_e", lcd_e, 0);
        check("midp_finish", lcd_finish, 0);
        check("midp_busy", busy, 0);
        check("midp_db", lcd_db, 8'h00);
        check("midp_idx", byte_idx, 0);
        check("midp_rs", lcd_rs, 0);
        lcd_enable = 1'b1;
        @(negedge clk_1ms);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_1ms);
        check("midp_idle_busy", busy, 0);
        check("midp_idle_e", lcd_e, 0);

        // Closed-loop sequence as issued by the sequencer
        for (int r = 0; r < 2; r++) begin
            run_xfer($sformatf("seq%0d_init", r), 2'd3, 1'b1, 1'b0, INIT_DATA, INIT_PULSE, 36, 1'b0, 1'b0);
            run_xfer($sformatf("seq%0d_addr", r), 2'd0, 1'b0, 1'b0, ADDR_DATA, ADDR_PULSE, 5, 1'b0, 1'b0);
            run_xfer($sformatf("seq%0d_ref", r), 2'd3, 1'b0, 1'b1, OPEN_DATA, OPEN_PULSE, 20, 1'b0, 1'b0);
            run_xfer($sformatf("seq%0d_addr2", r), 2'd0, 1'b0, 1'b0, ADDR_DATA, ADDR_PULSE, 5, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
